// File: rtl/ts_pkg.sv
// Shared transport-stream constants and types for the aligner and the packet RAM.
package ts_pkg;

    localparam int         TS_PACK_BYTE_SIZE = 188;
    localparam logic [7:0] TS_SYNC_BYTE      = 8'h47;
    localparam int         TS_PID_WIDTH      = 13;

    typedef enum logic [1:0] {
        TS_HUNT   = 2'd0,
        TS_VERIFY = 2'd1,
        TS_LOCKED = 2'd2
    } ts_state_t;

    function automatic logic [15:0] ts_sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ts_header_extract.sv
// Pulls PID and TEI out of bytes 1-2 of each aligned packet.
// Fed with the pre-register stream so its registered outputs line up with the forwarded byte.
module ts_header_extract
    import ts_pkg::*;
(
    input  logic                    mpeg_clk,
    input  logic                    mpeg_rst,
    input  logic [7:0]              byte_data,
    input  logic                    byte_valid,
    input  logic                    byte_sync,
    output logic [TS_PID_WIDTH-1:0] pid,
    output logic                    tei,
    output logic                    pid_valid
);

    typedef enum logic [1:0] {
        HDR_IDLE  = 2'd0,
        HDR_BYTE1 = 2'd1,
        HDR_BYTE2 = 2'd2
    } hdr_state_t;

    hdr_state_t              hdr_state_reg, hdr_state_next;
    logic [7:0]              byte1_reg, byte1_next;
    logic [TS_PID_WIDTH-1:0] pid_reg, pid_next;
    logic                    tei_reg, tei_next;
    logic                    pid_valid_reg, pid_valid_next;

    always_ff @(posedge mpeg_clk or posedge mpeg_rst) begin
        if (mpeg_rst) begin
            hdr_state_reg <= HDR_IDLE;
            byte1_reg     <= 8'h00;
            pid_reg       <= '0;
            tei_reg       <= 1'b0;
            pid_valid_reg <= 1'b0;
        end else begin
            hdr_state_reg <= hdr_state_next;
            byte1_reg     <= byte1_next;
            pid_reg       <= pid_next;
            tei_reg       <= tei_next;
            pid_valid_reg <= pid_valid_next;
        end
    end

    always_comb begin
        hdr_state_next = hdr_state_reg;
        byte1_next     = byte1_reg;
        pid_next       = pid_reg;
        tei_next       = tei_reg;
        pid_valid_next = 1'b0;
        if (byte_valid) begin
            // A sync always restarts the header walk, so an aborted packet cannot leak into the next
            if (byte_sync) begin
                hdr_state_next = HDR_BYTE1;
            end else begin
                case (hdr_state_reg)
                    HDR_BYTE1: begin
                        byte1_next     = byte_data;
                        hdr_state_next = HDR_BYTE2;
                    end
                    HDR_BYTE2: begin
                        pid_next       = {byte1_reg[4:0], byte_data};
                        tei_next       = byte1_reg[7];
                        pid_valid_next = 1'b1;
                        hdr_state_next = HDR_IDLE;
                    end
                    default: hdr_state_next = HDR_IDLE;
                endcase
            end
        end
    end

    assign pid       = pid_reg;
    assign tei       = tei_reg;
    assign pid_valid = pid_valid_reg;

endmodule

// File: rtl/ts_sync_aligner.sv
// Finds 188-byte TS packet boundaries on the 0x47 sync byte and forwards whole packets
// to logic_ram only while locked, with PID/TEI extraction and lock statistics.
module ts_sync_aligner
    import ts_pkg::*;
#(
    parameter int         PACK_BYTE_SIZE = TS_PACK_BYTE_SIZE,
    parameter logic [7:0] SYNC_BYTE      = TS_SYNC_BYTE,
    parameter int         LOCK_COUNT     = 3,
    parameter int         UNLOCK_COUNT   = 3
)(
    input  logic                    mpeg_clk,
    input  logic                    mpeg_rst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic [7:0]              mpeg_data,
    output logic                    mpeg_valid,
    output logic                    mpeg_sync,
    output logic                    locked,
    output logic [TS_PID_WIDTH-1:0] pid,
    output logic                    pid_valid,
    output logic                    tei,
    output logic                    sync_err,
    output logic [31:0]             pkt_cnt,
    output logic [15:0]             loss_cnt
);

    localparam int CNT_W = $clog2(PACK_BYTE_SIZE);
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);
    localparam int UNL_W = $clog2(UNLOCK_COUNT + 1);

    ts_state_t        state_reg, state_next;
    logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next, byte_cnt_adv;
    logic [LCK_W-1:0] good_cnt_reg, good_cnt_next;
    logic [UNL_W-1:0] miss_cnt_reg, miss_cnt_next;

    logic             at_sync, is_sync, last_byte;
    logic             fwd_valid, fwd_sync, sync_err_next, lock_lost;

    logic [7:0]       mpeg_data_reg;
    logic             mpeg_valid_reg, mpeg_sync_reg, sync_err_reg;
    logic [31:0]      pkt_cnt_reg;
    logic [15:0]      loss_cnt_reg;

    assign at_sync      = (byte_cnt_reg == '0);
    assign is_sync      = (in_data == SYNC_BYTE);
    assign last_byte    = (byte_cnt_reg == CNT_W'(PACK_BYTE_SIZE - 1));
    assign byte_cnt_adv = last_byte ? '0 : byte_cnt_reg + 1'b1;

    always_ff @(posedge mpeg_clk or posedge mpeg_rst) begin
        if (mpeg_rst) begin
            state_reg      <= TS_HUNT;
            byte_cnt_reg   <= '0;
            good_cnt_reg   <= '0;
            miss_cnt_reg   <= '0;
            mpeg_data_reg  <= 8'h00;
            mpeg_valid_reg <= 1'b0;
            mpeg_sync_reg  <= 1'b0;
            sync_err_reg   <= 1'b0;
            pkt_cnt_reg    <= 32'd0;
            loss_cnt_reg   <= 16'd0;
        end else begin
            state_reg      <= state_next;
            byte_cnt_reg   <= byte_cnt_next;
            good_cnt_reg   <= good_cnt_next;
            miss_cnt_reg   <= miss_cnt_next;
            mpeg_valid_reg <= fwd_valid;
            mpeg_sync_reg  <= fwd_sync;
            sync_err_reg   <= sync_err_next;
            if (fwd_valid) begin
                mpeg_data_reg <= in_data;
            end
            if (fwd_valid && last_byte) begin
                pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
            end
            if (lock_lost) begin
                loss_cnt_reg <= ts_sat_inc16(loss_cnt_reg);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        good_cnt_next = good_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        fwd_valid     = 1'b0;
        fwd_sync      = 1'b0;
        sync_err_next = 1'b0;
        lock_lost     = 1'b0;
        // A gap freezes everything: no branch below is taken without a valid byte
        if (in_valid) begin
            case (state_reg)
                TS_HUNT: begin
                    if (is_sync) begin
                        byte_cnt_next = CNT_W'(1);
                        good_cnt_next = LCK_W'(1);
                        state_next    = TS_VERIFY;
                    end
                end
                TS_VERIFY: begin
                    byte_cnt_next = byte_cnt_adv;
                    if (at_sync) begin
                        if (is_sync) begin
                            if (good_cnt_reg + 1'b1 == LCK_W'(LOCK_COUNT)) begin
                                state_next    = TS_LOCKED;
                                miss_cnt_next = '0;
                                fwd_valid     = 1'b1;
                                fwd_sync      = 1'b1;
                            end else begin
                                good_cnt_next = good_cnt_reg + 1'b1;
                            end
                        end else begin
                            // The failing byte is not a sync, so hunting resumes with the next one
                            state_next    = TS_HUNT;
                            good_cnt_next = '0;
                            byte_cnt_next = '0;
                        end
                    end
                end
                TS_LOCKED: begin
                    byte_cnt_next = byte_cnt_adv;
                    fwd_valid     = 1'b1;
                    fwd_sync      = at_sync;
                    if (at_sync) begin
                        if (is_sync) begin
                            miss_cnt_next = '0;
                        end else begin
                            sync_err_next = 1'b1;
                            if (miss_cnt_reg + 1'b1 == UNL_W'(UNLOCK_COUNT)) begin
                                state_next    = TS_HUNT;
                                byte_cnt_next = '0;
                                good_cnt_next = '0;
                                miss_cnt_next = '0;
                                fwd_valid     = 1'b0;
                                fwd_sync      = 1'b0;
                                lock_lost     = 1'b1;
                            end else begin
                                miss_cnt_next = miss_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_next    = TS_HUNT;
                    byte_cnt_next = '0;
                    good_cnt_next = '0;
                    miss_cnt_next = '0;
                end
            endcase
        end
    end

    ts_header_extract u_header_extract (
        .mpeg_clk   (mpeg_clk),
        .mpeg_rst   (mpeg_rst),
        .byte_data  (in_data),
        .byte_valid (fwd_valid),
        .byte_sync  (fwd_sync),
        .pid        (pid),
        .tei        (tei),
        .pid_valid  (pid_valid)
    );

    assign mpeg_data  = mpeg_data_reg;
    assign mpeg_valid = mpeg_valid_reg;
    assign mpeg_sync  = mpeg_sync_reg;
    assign locked     = (state_reg == TS_LOCKED);
    assign sync_err   = sync_err_reg;
    assign pkt_cnt    = pkt_cnt_reg;
    assign loss_cnt   = loss_cnt_reg;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Randomized bench for ts_sync_aligner against a position-arithmetic reference model.
module tb_ts_sync_aligner;
    import ts_pkg::*;

    localparam int LOCK_N   = 3;
    localparam int UNLOCK_N = 3;
    localparam int PKT      = TS_PACK_BYTE_SIZE;

    logic        mpeg_clk = 1'b0;
    logic        mpeg_rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [7:0]  mpeg_data;
    logic        mpeg_valid, mpeg_sync, locked, pid_valid, tei, sync_err;
    logic [12:0] pid;
    logic [31:0] pkt_cnt;
    logic [15:0] loss_cnt;

    ts_sync_aligner dut (
        .mpeg_clk   (mpeg_clk),
        .mpeg_rst   (mpeg_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .mpeg_data  (mpeg_data),
        .mpeg_valid (mpeg_valid),
        .mpeg_sync  (mpeg_sync),
        .locked     (locked),
        .pid        (pid),
        .pid_valid  (pid_valid),
        .tei        (tei),
        .sync_err   (sync_err),
        .pkt_cnt    (pkt_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 mpeg_clk = ~mpeg_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    // Reference model: offset of the next byte from the candidate anchor (-1 while hunting)
    int          m_dist;
    int          m_good, m_miss, m_pkt, m_loss;
    bit          m_locked;
    logic [12:0] m_pid;
    logic        m_tei;
    logic [7:0]  m_b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_dist = -1; m_good = 0; m_miss = 0; m_pkt = 0; m_loss = 0;
        m_locked = 0; m_pid = '0; m_tei = 1'b0; m_b1 = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] b, output bit fwd, output bit sy,
                              output bit err, output bit pidv);
        int pos;
        fwd = 0; sy = 0; err = 0; pidv = 0;
        if (m_dist < 0) begin
            if (b == TS_SYNC_BYTE) begin
                m_dist = 1;
                m_good = 1;
            end
            return;
        end
        pos = m_dist % PKT;
        m_dist++;
        if (!m_locked) begin
            if (pos == 0) begin
                if (b == TS_SYNC_BYTE) begin
                    m_good++;
                    if (m_good == LOCK_N) begin
                        m_locked = 1;
                        m_miss = 0;
                        fwd = 1;
                    end
                end else begin
                    m_dist = -1;
                    m_good = 0;
                end
            end
        end else begin
            fwd = 1;
            if (pos == 0 && b != TS_SYNC_BYTE) begin
                err = 1;
                m_miss++;
                if (m_miss == UNLOCK_N) begin
                    fwd = 0;
                    m_locked = 0;
                    m_dist = -1;
                    m_good = 0;
                    m_miss = 0;
                    if (m_loss < 65535) m_loss++;
                end
            end else if (pos == 0) begin
                m_miss = 0;
            end
        end
        if (fwd) begin
            sy = (pos == 0);
            if (pos == 1) m_b1 = b;
            if (pos == 2) begin
                pidv  = 1;
                m_pid = {m_b1[4:0], b};
                m_tei = m_b1[7];
            end
            if (pos == PKT - 1) m_pkt++;
        end
    endtask

    task automatic compare_cycle(input bit fwd, input logic [7:0] d, input bit sy,
                                 input bit err, input bit pidv);
        chk("mpeg_valid", 32'(mpeg_valid), 32'(fwd));
        if (fwd) chk("mpeg_data", 32'(mpeg_data), 32'(d));
        chk("mpeg_sync", 32'(mpeg_sync), 32'(sy));
        chk("sync_err", 32'(sync_err), 32'(err));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("pid_valid", 32'(pid_valid), 32'(pidv));
        chk("pid", 32'(pid), 32'(m_pid));
        chk("tei", 32'(tei), 32'(m_tei));
        chk("pkt_cnt", pkt_cnt, 32'(m_pkt));
        chk("loss_cnt", 32'(loss_cnt), 32'(m_loss));
        if (sync_err) err_seen++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mpeg_data"}, 32'(mpeg_data), 32'd0);
        chk({tag, "_mpeg_valid"}, 32'(mpeg_valid), 32'd0);
        chk({tag, "_mpeg_sync"}, 32'(mpeg_sync), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_pid"}, 32'(pid), 32'd0);
        chk({tag, "_pid_valid"}, 32'(pid_valid), 32'd0);
        chk({tag, "_tei"}, 32'(tei), 32'd0);
        chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 32'd0);
        chk({tag, "_loss_cnt"}, 32'(loss_cnt), 32'd0);
    endtask

    function automatic logic [7:0] rand_nonsync();
        logic [7:0] v;
        v = 8'($urandom);
        if (v == TS_SYNC_BYTE) v = 8'h00;
        return v;
    endfunction

    // gm: 0 = continuous, 1 = one idle cycle after every byte, 2 = random idle bursts
    task automatic send_byte(input logic [7:0] b, input int gm);
        bit fwd, sy, err, pidv;
        int gaps;
        in_valid = 1'b1;
        in_data  = b;
        model_step(b, fwd, sy, err, pidv);
        @(negedge mpeg_clk);
        compare_cycle(fwd, b, sy, err, pidv);
        gaps = 0;
        if (gm == 1) gaps = 1;
        else if (gm == 2 && $urandom_range(0, 3) == 0) gaps = int'($urandom_range(1, 3));
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge mpeg_clk);
            compare_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_packet(input logic [7:0] sb, input logic [12:0] p, input int gm,
                               input int nbytes);
        logic [7:0] b;
        logic       t;
        t = 1'($urandom_range(0, 1));
        for (int i = 0; i < nbytes; i++) begin
            if (i == 0)      b = sb;
            else if (i == 1) b = {t, 2'($urandom_range(0, 3)), p[12:8]};
            else if (i == 2) b = p[7:0];
            else             b = rand_nonsync();
            send_byte(b, gm);
        end
    endtask

    task automatic send_junk(input int n, input int gm);
        for (int i = 0; i < n; i++) send_byte(rand_nonsync(), gm);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        in_data  = 8'h00;
        mpeg_rst = 1'b1;
        @(negedge mpeg_clk);
        check_zero(tag);
        mpeg_rst = 1'b0;
        model_reset();
        err_seen = 0;
    endtask

    initial begin
        mpeg_rst = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();

        // Aligned stream
        do_reset("rst0");
        for (int k = 0; k < 5; k++) send_packet(TS_SYNC_BYTE, 13'h157F, 0, PKT);
        chk("aligned_pkt_cnt", pkt_cnt, 32'd3);
        chk("aligned_pid", 32'(pid), 32'h157F);
        chk("aligned_locked", 32'(locked), 32'd1);

        // Misaligned start
        do_reset("rst1");
        send_junk(50, 0);
        for (int k = 0; k < 4; k++) send_packet(TS_SYNC_BYTE, 13'(k + 40), 0, PKT);
        chk("misaligned_pkt_cnt", pkt_cnt, 32'd2);

        // False sync at offset 10
        do_reset("rst2");
        send_junk(10, 0);
        send_byte(TS_SYNC_BYTE, 0);
        send_junk(177, 0);
        for (int k = 0; k < 5; k++) send_packet(TS_SYNC_BYTE, 13'h0AAA, 0, PKT);
        chk("falsesync_pkt_cnt", pkt_cnt, 32'd2);

        // Isolated corrupted syncs never accumulate into an unlock
        do_reset("rst3");
        for (int k = 0; k < 4; k++) send_packet(TS_SYNC_BYTE, 13'h0123, 0, PKT);
        send_packet(8'h00, 13'h0123, 0, PKT);
        send_packet(TS_SYNC_BYTE, 13'h0123, 0, PKT);
        send_packet(TS_SYNC_BYTE, 13'h0123, 0, PKT);
        chk("single_err_cnt", 32'(err_seen), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
        chk("single_pkt_cnt", pkt_cnt, 32'd5);
        send_packet(8'h00, 13'h0123, 0, PKT);
        send_packet(8'h12, 13'h0123, 0, PKT);
        send_packet(TS_SYNC_BYTE, 13'h0123, 0, PKT);
        send_packet(8'hB8, 13'h0123, 0, PKT);
        send_packet(8'h46, 13'h0123, 0, PKT);
        chk("missreset_locked", 32'(locked), 32'd1);
        chk("missreset_err_cnt", 32'(err_seen), 32'd5);

        // Three consecutive corrupted syncs
        do_reset("rst4");
        for (int k = 0; k < 4; k++) send_packet(TS_SYNC_BYTE, 13'h1FFF, 0, PKT);
        for (int k = 0; k < 3; k++) send_packet(8'h00, 13'h1FFF, 0, PKT);
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_loss_cnt", 32'(loss_cnt), 32'd1);
        for (int k = 0; k < 4; k++) send_packet(TS_SYNC_BYTE, 13'h1FFF, 0, PKT);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_pkt_cnt", pkt_cnt, 32'd6);

        // Toggled in_valid, then reset mid-packet
        do_reset("rst5");
        for (int k = 0; k < 5; k++) send_packet(TS_SYNC_BYTE, 13'h0191, 1, PKT);
        chk("gaps_pid", 32'(pid), 32'h0191);
        chk("gaps_pkt_cnt", pkt_cnt, 32'd3);
        send_packet(TS_SYNC_BYTE, 13'h0191, 1, 50);
        in_valid = 1'b0;
        #2 mpeg_rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge mpeg_clk);
        mpeg_rst = 1'b0;
        model_reset();
        @(negedge mpeg_clk);
        compare_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_junk(100, 2);
        for (int k = 0; k < 3; k++) send_packet(TS_SYNC_BYTE, 13'h0191, 2, PKT);
        chk("postrst_pkt_cnt", pkt_cnt, 32'd1);

        // Random stream with random gaps, junk, PIDs and occasional corruption
        do_reset("rst6");
        send_junk(int'($urandom_range(1, 300)), 2);
        for (int k = 0; k < 10; k++) begin
            logic [7:0] sb;
            sb = ($urandom_range(0, 4) == 0) ? rand_nonsync() : TS_SYNC_BYTE;
            send_packet(sb, 13'($urandom), 2, PKT);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ts_sync_aligner.md
Name: ts_sync_aligner

Overview:
- Front-end stage that sits directly upstream of logic_ram on the mpeg_clk domain.
- Takes a raw, possibly misaligned transport-stream byte stream and finds 188-byte packet boundaries using the 0x47 sync byte.
- Drives logic_ram's mpeg_data/mpeg_valid/mpeg_sync, forwarding whole packets only, and only while locked.
- Also extracts the PID and TEI of each packet and keeps lock/loss statistics for AXI readback.

Parameters:
- PACK_BYTE_SIZE, 188, packet length in bytes.
- SYNC_BYTE, 8'h47, sync byte value.
- LOCK_COUNT, 3, consecutive correctly spaced sync bytes required to enter LOCKED (minimum 2).
- UNLOCK_COUNT, 3, consecutive missed sync bytes while LOCKED that force HUNT (minimum 1).

Ports:
- mpeg_clk, in, 1: stream clock.
- mpeg_rst, in, 1: asynchronous, active-high reset.
- in_data, in, 8: raw TS byte.
- in_valid, in, 1: in_data qualifier; gaps are allowed at any byte.
- mpeg_data, out, 8: aligned byte to logic_ram.
- mpeg_valid, out, 1: mpeg_data qualifier.
- mpeg_sync, out, 1: high with the first (0x47) byte of each forwarded packet.
- locked, out, 1: aligner is in LOCKED.
- pid, out, 13: PID of the current packet, held until the next update.
- pid_valid, out, 1: one-cycle pulse when pid is updated.
- tei, out, 1: transport_error_indicator of the current packet, updated together with pid.
- sync_err, out, 1: one-cycle pulse on each missed sync byte while LOCKED.
- pkt_cnt, out, 32: forwarded packets, wraps modulo 2^32.
- loss_cnt, out, 16: LOCKED-to-HUNT transitions, saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, release synchronous to mpeg_clk):
  - All outputs 0; state HUNT.
  - byte_cnt, good_cnt, miss_cnt all 0.
- byte_cnt (0..PACK_BYTE_SIZE-1) advances only on cycles with in_valid=1 and wraps to 0 after PACK_BYTE_SIZE-1. A byte at byte_cnt==0 is at the "sync position".
- HUNT:
  - locked=0; nothing forwarded.
  - Valid byte == SYNC_BYTE → byte_cnt<=1, good_cnt<=1, go to VERIFY.
- VERIFY:
  - Nothing forwarded.
  - At the sync position, byte == SYNC_BYTE:
    - good_cnt+1 == LOCK_COUNT → go to LOCKED, miss_cnt<=0, and forward this byte as the first packet byte.
    - Otherwise good_cnt<=good_cnt+1.
  - At the sync position, byte != SYNC_BYTE → go to HUNT, good_cnt<=0. The byte is not re-examined, since it cannot be a sync.
- LOCKED:
  - locked=1; every valid byte is forwarded.
  - Sync position, byte == SYNC_BYTE → miss_cnt<=0.
  - Sync position, byte != SYNC_BYTE → sync_err pulse, miss_cnt<=miss_cnt+1.
    - If miss_cnt+1 == UNLOCK_COUNT: go to HUNT; the byte is not forwarded; loss_cnt++ (saturating); the in-progress packet is aborted.
    - Otherwise the packet is forwarded normally, with mpeg_sync high on its first byte.
- Output timing:
  - Latency is 1 cycle: input byte on cycle N appears on mpeg_data at cycle N+1.
  - mpeg_valid is low during input gaps.
  - mpeg_sync is only ever high together with mpeg_valid.
- PID/TEI extraction, for forwarded packets only:
  - Capture byte 1; on byte 2, pid <= {byte1[4:0], byte2} and tei <= byte1[7].
  - pid_valid pulses in the same cycle byte 2 appears on mpeg_data.
- pkt_cnt increments when the last byte (index PACK_BYTE_SIZE-1) of a forwarded packet is output. Partially forwarded packets aborted by unlock are not counted.
- in_valid low mid-packet: all state frozen; no timeout.
- Reset mid-packet: output stops immediately, and the next lock starts from a fresh sync. logic_ram discards its partial packet on the next mpeg_sync.

Decomposition:
- Shared package ts_pkg:
  - TS_PACK_BYTE_SIZE=188, TS_SYNC_BYTE=8'h47, TS_PID_WIDTH=13.
  - State encoding: HUNT=0, VERIFY=1, LOCKED=2.
  - The same 188 constant used by logic_ram.
- One natural sub-module: ts_header_extract. It takes the aligned byte, valid and sync, and produces pid/tei/pid_valid, so logic_ram's filter path can reuse it.
- The FSM and counters stay in the top module.

Test Plan:
- Aligned stream: 5 packets of 0x47+187 bytes, in_valid=1, PID 0x157F. Required: locked rises at the 3rd sync byte; first mpeg_sync 1 cycle later; pid=13'h157F with pid_valid on byte 2; pkt_cnt=3.
- Misaligned start: 50 junk bytes (no 0x47), then 4 packets. Required: no mpeg_valid during junk; lock at the 3rd packet's sync; pkt_cnt=2.
- False sync: a 0x47 at data offset 10 inside a packet before real packets. Required: VERIFY fails at offset 198 and returns to HUNT; aligner still locks on the true boundary; no false mpeg_sync.
- Single corrupted sync: while LOCKED, packet 2's sync byte = 0x00. Required: sync_err pulse once; locked stays 1; packet forwarded with mpeg_sync=1; miss_cnt returns to 0 on the next good sync.
- Three consecutive corrupted syncs: required locked drops at the 3rd; that byte is not forwarded; loss_cnt=1; relock after 3 good syncs.
- Gaps and reset: in_valid toggled 1/0 every cycle, PID 0x0191. Required: identical forwarded byte sequence; pid=13'h0191. Then assert mpeg_rst mid-packet: all outputs 0 asynchronously; after release, HUNT.
